// File: rtl/sel_rr_arbiter.sv
// sel_rr_arbiter
//
// Round-robin arbiter that shares one 4-to-16 select decoder among 16 requesters.
// The winner's index drives the decoder select. The grant is held until the owner
// signals done, drops its request, or reaches the hold limit. Every release is
// followed by exactly one dead cycle, so decoded enables never overlap between owners.
//
// Parameters
//   MAX_HOLD   maximum cycles a single grant may be held (legal range 2..256)
//
// Ports
//   clock      rising-edge clock for all state
//   reset      synchronous, active-high reset
//   en         arbitration enable; gates new grants only, never revokes one
//   req[15:0]  request vector, bit i = requester i wants the decoder
//   done       owner's end-of-transfer strobe, ignored when no grant is active
//   sel[3:0]   index of the current or most recent owner (decoder select)
//   gnt_valid  high while sel names an active owner
//   timeout    one-cycle pulse (during the gap) when the hold limit revoked a grant
//   busy       high in the grant and gap states
//
// All outputs come straight from registers; there is no input-to-output path.

module sel_rr_arbiter #(
  parameter int unsigned MAX_HOLD = 64
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        en,
  input  logic [15:0] req,
  input  logic        done,
  output logic [3:0]  sel,
  output logic        gnt_valid,
  output logic        timeout,
  output logic        busy
);

  // Value of hold_cnt on the last cycle a grant may still be held.
  localparam logic [7:0] HoldLast = 8'(MAX_HOLD - 1);

  typedef enum logic [1:0] {
    StIdle,
    StGrant,
    StGap
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  sel_q, sel_d;
  logic        gnt_valid_q, gnt_valid_d;
  logic        timeout_q, timeout_d;
  logic [3:0]  last_q, last_d;
  logic [7:0]  hold_cnt_q, hold_cnt_d;

  // ---------------------------------------------------------------------------
  // Winner search
  // ---------------------------------------------------------------------------
  // Scan offsets 16 down to 1 from last and keep overwriting, so the final value
  // is the requester closest above last. Offset 16 wraps back onto last itself,
  // which makes the previous owner the lowest-priority candidate.
  logic [3:0] winner;
  logic [3:0] cand;
  logic       any_req;

  always_comb begin
    winner = last_q;
    cand   = last_q;
    for (int k = 16; k >= 1; k--) begin
      cand = last_q + 4'(k);
      if (req[cand]) begin
        winner = cand;
      end
    end
  end

  assign any_req = |req;

  // ---------------------------------------------------------------------------
  // Release decode for an active grant
  // ---------------------------------------------------------------------------
  logic hold_limit;
  logic owner_req;
  logic release_grant;

  assign hold_limit    = (hold_cnt_q == HoldLast);
  assign owner_req     = req[sel_q];
  assign release_grant = done | ~owner_req | hold_limit;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  logic start_grant;

  assign start_grant = en & any_req;

  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    gnt_valid_d = gnt_valid_q;
    timeout_d   = 1'b0;
    last_d      = last_q;
    hold_cnt_d  = hold_cnt_q;

    unique case (state_q)
      StIdle: begin
        if (start_grant) begin
          state_d     = StGrant;
          sel_d       = winner;
          gnt_valid_d = 1'b1;
          hold_cnt_d  = 8'd0;
        end
      end

      StGrant: begin
        if (release_grant) begin
          state_d     = StGap;
          gnt_valid_d = 1'b0;
          last_d      = sel_q;
          // A release that coincides with done or a dropped request is not a timeout.
          timeout_d   = hold_limit & ~done & owner_req;
        end else begin
          hold_cnt_d  = hold_cnt_q + 8'd1;
        end
      end

      StGap: begin
        // Search here already sees last updated to the releasing owner.
        if (start_grant) begin
          state_d     = StGrant;
          sel_d       = winner;
          gnt_valid_d = 1'b1;
          hold_cnt_d  = 8'd0;
        end else begin
          state_d     = StIdle;
        end
      end

      default: begin
        state_d     = StIdle;
        gnt_valid_d = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= StIdle;
      sel_q       <= 4'd0;
      gnt_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
      last_q      <= 4'd15;  // first search after reset starts at index 0
      hold_cnt_q  <= 8'd0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      gnt_valid_q <= gnt_valid_d;
      timeout_q   <= timeout_d;
      last_q      <= last_d;
      hold_cnt_q  <= hold_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign sel       = sel_q;
  assign gnt_valid = gnt_valid_q;
  assign timeout   = timeout_q;
  assign busy      = (state_q != StIdle);

endmodule

// File: doc/sel_rr_arbiter.md
# sel_rr_arbiter

Round-robin arbiter that shares the 4-to-16 select decoder among 16 requesters. Each cycle it is free, it picks one active requester, drives that requester's index onto the decoder select, and holds the grant until the requester signals completion, drops its request, or exceeds a hold limit. A mandatory one-cycle dead gap separates consecutive grants, so the decoded one-hot enables never overlap between owners.

## Interface
- MAX_HOLD, 64, maximum cycles a single grant may be held; legal range 2..256.
- clock  input  1  rising-edge clock for all state.
- reset  input  1  synchronous, active-high; all state takes reset values at the next rising edge.
- en  input  1  arbitration enable; when low, no new grant is issued and a grant in progress is unaffected.
- req  input  16  request vector; bit i high = requester i wants the decoder.
- done  input  1  owner's end-of-transfer strobe; ignored unless gnt_valid = 1.
- sel  output  4  index of the current/last owner; drives the decoder select.
- gnt_valid  output  1  high while sel names an active owner; gates the decoder output downstream.
- timeout  output  1  one-cycle pulse when a grant is revoked by the hold limit.
- busy  output  1  high in GRANT and GAP states.

## Operation
- State machine: IDLE, GRANT, GAP. Registered state, sel, gnt_valid, timeout, last-owner pointer `last` (4 b), hold counter `hold_cnt` (8 b).
- Winner search: first i with req[i] = 1, scanning from (last+1) mod 16 upward and wrapping past 15 to 0. Pure 4-bit wrap arithmetic.
- IDLE: at an edge with en = 1 and req != 0 -> GRANT; sel <= winner; gnt_valid <= 1; hold_cnt <= 0. Otherwise stay.
- GRANT: release condition = done, or req[sel] = 0, or hold_cnt = MAX_HOLD-1. On release -> GAP; gnt_valid <= 0; last <= sel; timeout <= 1 only if the hold limit was reached and done = 0 and req[sel] = 1. Otherwise hold_cnt <= hold_cnt+1.
- GAP: exactly one cycle. At its closing edge, apply the same rule as IDLE (en = 1 and req != 0 -> GRANT with a new search from last+1), else -> IDLE.
- The releasing owner is lowest priority in the next search. It can win again only if no other bit is set.
- Simultaneous done and hold limit: the release counts as done, so timeout stays 0.
- en falling during GRANT does not revoke the grant.
- sel keeps the last owner's index in IDLE and GAP. Consumers use gnt_valid, not sel, as ownership.
- Reset values: state IDLE, sel 0, gnt_valid 0, timeout 0, busy 0, hold_cnt 0, last 15 (first search starts at index 0). Reset in any state aborts the grant immediately at the next edge. No gap cycle is inserted.

## Timing
- Request to grant: req sampled at edge t in IDLE -> gnt_valid and sel valid after edge t (1 cycle).
- Release: done sampled at edge t -> gnt_valid low after t. GAP lasts t..t+1. The earliest next grant is visible after edge t+1.
- Hold limit: grant asserted after edge g is revoked after edge g+MAX_HOLD. gnt_valid is high for exactly MAX_HOLD cycles. The timeout pulse is high for the one GAP cycle.
- Back-to-back owners under continuous requests: pattern of MAX_HOLD cycles high, 1 cycle low.
- No combinational path from inputs to outputs. All outputs are registered.

## Test plan
- Reset with req = 16'h8001 -> the first grant after reset is sel = 0. After done, the next grant is sel = 15 following one gnt_valid-low cycle.
- req = 16'hFFFF held, done pulsed one cycle after each grant -> the sel sequence is 0,1,2,…,15,0 with a gap cycle between each. No index is skipped or repeated.
- req = 16'h0010 only, never done, MAX_HOLD = 64 -> gnt_valid is high for 64 cycles, then timeout = 1 for one cycle, then sel = 4 is re-granted.
- Grant to sel = 7; deassert req[7] at edge t -> gnt_valid = 0 after t, and timeout stays 0. done pulsed while gnt_valid = 0 has no effect.
- done and the hold limit coincide on the same edge -> release with timeout = 0. In a separate run, assert reset mid-GRANT -> all outputs return to their reset values at the next edge, and the next grant starts its search at 0.
- en = 0 with req = 16'h0003 -> no grant. Raise en -> sel = 0 one cycle later. Drop en during that grant -> the grant continues until done.
